conv5x5_mac_pipe: RTL and testbench

Downstream consumer of the 5x5 sliding-window line buffer in the 28x28 convolution path.
- Takes one flattened KX*KY window per valid cycle and computes the signed dot product with a runtime-loaded kernel, plus a bias.
- Fully pipelined: accepts one window per cycle, result after a fixed 3-cycle latency.
- Kernel and bias are loaded through a serial word port before streaming starts.

---
 rtl/conv_pkg.sv | 20 ++
 rtl/conv_row_mac.sv | 44 ++++
 rtl/conv5x5_mac_pipe.sv | 119 +++++++++++
 tb/tb_conv5x5_mac_pipe.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants, widths and helpers for the 5x5 convolution MAC pipeline.
package conv_pkg;
  localparam int I_F_BW  = 8;
  localparam int W_BW    = 8;
  localparam int B_BW    = 16;
  localparam int KX      = 5;
  localparam int KY      = 5;
  localparam int KN      = KX * KY;
  localparam int P_BW    = I_F_BW + W_BW;
  localparam int R_BW    = P_BW + $clog2(KX);
  localparam int O_BW    = I_F_BW + W_BW + $clog2(KN) + 1;
  localparam int N_WORDS = KN + 1;
  localparam int CNT_BW  = $clog2(N_WORDS);

  typedef enum logic {ST_LOADING, ST_LOADED} load_state_e;

  function automatic int elem_off(input int wy, input int wx);
    return (wy * KX + wx) * I_F_BW;
  endfunction
endpackage

// File: rtl/conv_row_mac.sv
// One window row: KX unsigned-pixel x signed-weight products (S1) and their row sum (S2).
module conv_row_mac
  import conv_pkg::*;
(
  input  logic                       clk,
  input  logic                       i_en_s1,
  input  logic                       i_en_s2,
  input  logic [KX*I_F_BW-1:0]       i_pix,
  input  logic [KX*W_BW-1:0]         i_wts,
  output logic signed [R_BW-1:0]     o_row_sum
);
  logic signed [P_BW-1:0] w_prod [KX];
  logic signed [P_BW-1:0] r_prod [KX];
  logic signed [R_BW-1:0] w_sum;
  logic signed [R_BW-1:0] r_row_sum;

  // Pixel gets a zero sign bit so the product stays exact at 255 * -128.
  always_comb begin
    for (int wx = 0; wx < KX; wx++) begin
      w_prod[wx] = P_BW'($signed({1'b0, i_pix[wx*I_F_BW +: I_F_BW]}))
                 * P_BW'($signed(i_wts[wx*W_BW +: W_BW]));
    end
  end

  always_comb begin
    w_sum = '0;
    for (int wx = 0; wx < KX; wx++) begin
      w_sum = w_sum + R_BW'(r_prod[wx]);
    end
  end

  always_ff @(posedge clk) begin
    if (i_en_s1) begin
      for (int wx = 0; wx < KX; wx++) begin
        r_prod[wx] <= w_prod[wx];
      end
    end
    if (i_en_s2) begin
      r_row_sum <= w_sum;
    end
  end

  assign o_row_sum = r_row_sum;
endmodule

// File: rtl/conv5x5_mac_pipe.sv
// 5x5 window dot product with runtime-loaded kernel and bias, 3-cycle pipeline.
// Optional CONV5X5_RELU_EN clamps negative results to zero in the S3 register.
//
// state      | meaning
// ST_LOADING | collecting kernel words 0..24 then bias word 25
// ST_LOADED  | kernel and bias resident, windows accepted
module conv5x5_mac_pipe
  import conv_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_w_valid,
  input  logic [B_BW-1:0]        i_w_data,
  output logic                   o_w_loaded,
  input  logic                   i_in_valid,
  input  logic [KN*I_F_BW-1:0]   i_window,
  output logic                   o_valid,
  output logic [O_BW-1:0]        o_result
);
  load_state_e             r_state, w_next_state;
  logic [CNT_BW-1:0]       r_cnt;
  logic                    w_last_word;
  logic                    w_wt_we, w_bias_we;
  logic [CNT_BW-1:0]       w_wt_idx;
  logic signed [W_BW-1:0]  r_wt [KN];
  logic signed [B_BW-1:0]  r_bias;
  logic                    w_accept;
  logic [2:0]              r_vld;
  logic [KY-1:0][KX*W_BW-1:0] w_row_wts;
  logic signed [R_BW-1:0]  w_row_sum [KY];
  logic signed [O_BW-1:0]  w_total, w_s3;
  logic [O_BW-1:0]         r_result;

  assign w_last_word = (r_cnt == CNT_BW'(N_WORDS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_LOADING;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_LOADING: if (i_w_valid && w_last_word) w_next_state = ST_LOADED;
      ST_LOADED:  if (i_w_valid)                w_next_state = ST_LOADING;
      default:                                  w_next_state = ST_LOADING;
    endcase
  end

  // A word arriving while loaded starts a reload and lands in weight 0.
  always_comb begin
    o_w_loaded = (r_state == ST_LOADED);
    w_wt_we    = i_w_valid && ((r_state == ST_LOADED) || !w_last_word);
    w_wt_idx   = (r_state == ST_LOADED) ? '0 : r_cnt;
    w_bias_we  = i_w_valid && (r_state == ST_LOADING) && w_last_word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_w_valid) begin
      if (r_state == ST_LOADED) r_cnt <= CNT_BW'(1);
      else if (w_last_word)     r_cnt <= '0;
      else                      r_cnt <= r_cnt + CNT_BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wt_we)   r_wt[w_wt_idx] <= i_w_data[W_BW-1:0];
    if (w_bias_we) r_bias         <= i_w_data;
  end

  assign w_accept = i_in_valid && o_w_loaded;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_vld <= '0;
    else          r_vld <= {r_vld[1:0], w_accept};
  end

  always_comb begin
    w_row_wts = '0;
    for (int wy = 0; wy < KY; wy++) begin
      for (int wx = 0; wx < KX; wx++) begin
        w_row_wts[wy][wx*W_BW +: W_BW] = r_wt[wy*KX + wx];
      end
    end
  end

  for (genvar gy = 0; gy < KY; gy++) begin : g_row
    conv_row_mac u_row (
      .clk       (clk),
      .i_en_s1   (w_accept),
      .i_en_s2   (r_vld[0]),
      .i_pix     (i_window[elem_off(gy, 0) +: KX*I_F_BW]),
      .i_wts     (w_row_wts[gy]),
      .o_row_sum (w_row_sum[gy])
    );
  end

  always_comb begin
    w_total = O_BW'(r_bias);
    for (int wy = 0; wy < KY; wy++) begin
      w_total = w_total + O_BW'(w_row_sum[wy]);
    end
`ifdef CONV5X5_RELU_EN
    w_s3 = w_total[O_BW-1] ? '0 : w_total;
`else
    w_s3 = w_total;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_result <= '0;
    else if (r_vld[1]) r_result <= w_s3;
  end

  assign o_valid  = r_vld[2];
  assign o_result = r_result;
endmodule

// File: tb/tb_conv5x5_mac_pipe.sv
// Directed + scoreboard bench for conv5x5_mac_pipe (honours CONV5X5_RELU_EN in its model).
module tb_conv5x5_mac_pipe;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         i_w_valid = 1'b0;
  logic [15:0]  i_w_data = '0;
  logic         o_w_loaded;
  logic         i_in_valid = 1'b0;
  logic [199:0] i_window = '0;
  logic         o_valid;
  logic [21:0]  o_result;

  conv5x5_mac_pipe dut (
    .clk(clk), .reset_n(reset_n), .i_w_valid(i_w_valid), .i_w_data(i_w_data),
    .o_w_loaded(o_w_loaded), .i_in_valid(i_in_valid), .i_window(i_window),
    .o_valid(o_valid), .o_result(o_result)
  );

  always #5 clk = ~clk;

  typedef struct { logic [21:0] res; int due; } exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [21:0] last_res = '0;

  int m_w[25];
  int m_b = 0;
  int m_cnt = 0;
  bit m_loaded = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: reset values, scoreboard pops with latency, hold while idle.
  always @(negedge clk) begin
    if (!reset_n) begin
      n_checks++;
      assert (o_valid === 1'b0 && o_result === 22'd0) else begin
        n_errors++;
        $error("FAIL reset_out: observed valid=%b result=%0d expected valid=0 result=0", o_valid, o_result);
      end
      last_res = '0;
    end else if (o_valid === 1'b1) begin
      n_checks++;
      assert (q.size() != 0) else begin
        n_errors++;
        $error("FAIL unexpected_valid: observed result=%0d expected no valid", $signed(o_result));
      end
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        n_checks++;
        assert (o_result === e.res && cyc == e.due) else begin
          n_errors++;
          $error("FAIL result: observed %0d at cycle %0d expected %0d at cycle %0d",
                 $signed(o_result), cyc, $signed(e.res), e.due);
        end
        last_res = e.res;
      end
    end else begin
      n_checks++;
      assert (o_result === last_res) else begin
        n_errors++;
        $error("FAIL hold: observed %0d expected %0d", $signed(o_result), $signed(last_res));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [21:0] model(input int p[25]);
    longint s;
    logic [63:0] v;
    s = m_b;
    for (int k = 0; k < 25; k++) s += longint'(p[k]) * longint'(m_w[k]);
`ifdef CONV5X5_RELU_EN
    if (s < 0) s = 0;
`endif
    v = 64'(s);
    return v[21:0];
  endfunction

  task automatic load_word(input int v);
    i_w_data  = 16'(v);
    i_w_valid = 1'b1;
    if (m_loaded) begin
      m_loaded = 1'b0;
      m_w[0] = v;
      m_cnt = 1;
    end else if (m_cnt == 25) begin
      m_b = v;
      m_loaded = 1'b1;
      m_cnt = 0;
    end else begin
      m_w[m_cnt] = v;
      m_cnt++;
    end
    step();
    i_w_valid = 1'b0;
  endtask

  task automatic load_all(input int w[25], input int b);
    for (int k = 0; k < 25; k++) load_word(w[k]);
    load_word(b);
  endtask

  task automatic send_window(input int p[25]);
    for (int k = 0; k < 25; k++) i_window[k*8 +: 8] = 8'(p[k]);
    i_in_valid = 1'b1;
    if (m_loaded) q.push_back('{res: model(p), due: cyc + 3});
    step();
    i_in_valid = 1'b0;
  endtask

  task automatic check_loaded(input bit exp, input string tag);
    n_checks++;
    assert (o_w_loaded === exp) else begin
      n_errors++;
      $error("FAIL %s: observed o_w_loaded=%b expected %b", tag, o_w_loaded, exp);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    repeat (2) step();
    n_checks++;
    assert (q.size() == 0) else begin
      n_errors++;
      $error("FAIL drain: observed %0d pending results expected 0", q.size());
    end
  endtask

  initial begin
    int w[25];
    int p[25];

    repeat (3) step();
    check_loaded(1'b0, "reset_loaded");
    reset_n = 1'b1;
    step();

    // all-ones kernel, flat 10 window -> 250
    for (int k = 0; k < 25; k++) begin w[k] = 1; p[k] = 10; end
    load_all(w, 0);
    check_loaded(1'b1, "loaded_t1");
    send_window(p);
    drain();

    // single centre tap, bias -5 -> 195
    for (int k = 0; k < 25; k++) begin w[k] = 0; p[k] = 255; end
    w[12] = 1; p[12] = 200;
    load_all(w, -5);
    send_window(p);
    drain();

    // extreme negative range -> -816000 (0 when clamped)
    for (int k = 0; k < 25; k++) begin w[k] = -128; p[k] = 255; end
    load_all(w, 0);
    send_window(p);
    drain();

    // 10 back-to-back windows, pixel = index
    for (int k = 0; k < 25; k++) w[k] = 1;
    load_all(w, 0);
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 25; k++) p[k] = i;
      send_window(p);
    end
    drain();

    // random kernels/windows with idle gaps and ignored garbage
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 25; k++) w[k] = int'($urandom_range(255)) - 128;
      load_all(w, int'($urandom_range(65535)) - 32768);
      for (int i = 0; i < 4; i++) begin
        for (int k = 0; k < 25; k++) p[k] = int'($urandom_range(255));
        send_window(p);
        if (i == 1) begin
          i_window = {7{$urandom()}};
          step();
        end
      end
      drain();
    end

    // partial reload: window dropped until all 26 words are in
    for (int k = 0; k < 25; k++) begin w[k] = k - 12; p[k] = 3 * k; end
    for (int k = 0; k < 20; k++) load_word(w[k]);
    check_loaded(1'b0, "partial_loaded");
    send_window(p);
    drain();
    for (int k = 20; k < 25; k++) load_word(w[k]);
    load_word(77);
    check_loaded(1'b1, "full_loaded");
    send_window(p);
    drain();

    // reset with two windows in flight
    for (int k = 0; k < 25; k++) p[k] = 100 + k;
    send_window(p);
    send_window(p);
    reset_n = 1'b0;
    q.delete();
    m_loaded = 1'b0;
    m_cnt = 0;
    step();
    reset_n = 1'b1;
    check_loaded(1'b0, "reset_mid_loaded");
    send_window(p);
    drain();
    for (int k = 0; k < 25; k++) w[k] = 2;
    load_all(w, 1);
    send_window(p);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
